// File: rtl/des_key_schedule_if.sv
// Handshake bundle between a key source, the DES key schedule and the round datapath.
// The slave modport is the schedule itself; the master modport drives keys and consumes subkeys.
interface des_key_schedule_if;
  logic [63:0] key_in;
  logic        decrypt;
  logic        key_load;
  logic        idle;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic [3:0]  round;
  logic        last;

  modport master (
    output key_in, decrypt, key_load, subkey_ready,
    input  idle, subkey_valid, subkey, round, last
  );

  modport slave (
    input  key_in, decrypt, key_load, subkey_ready,
    output idle, subkey_valid, subkey, round, last
  );
endinterface

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: streams K1..K16 (or K16..K1) from rotating C/D halves,
// one subkey per valid/ready handshake, with no subkey storage.
module des_key_schedule (
  input logic             clk,
  input logic             rst,
  des_key_schedule_if.slave bus
);
  typedef enum logic [0:0] {StIdle, StRound} state_e;

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic        mode_q, mode_d;

  logic [63:0] k;
  logic [27:0] c0, d0;
  logic [55:0] cd;
  logic        fire;
  logic        single_shift;
  logic        unused_parity;

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  assign k = bus.key_in;
  assign unused_parity = ^{k[56], k[48], k[40], k[32], k[24], k[16], k[8], k[0]};

  // PC-1: DES key bit n lives at k[64-n]
  assign c0 = {k[7],  k[15], k[23], k[31], k[39], k[47], k[55], k[63],
               k[6],  k[14], k[22], k[30], k[38], k[46], k[54], k[62],
               k[5],  k[13], k[21], k[29], k[37], k[45], k[53], k[61],
               k[4],  k[12], k[20], k[28]};
  assign d0 = {k[1],  k[9],  k[17], k[25], k[33], k[41], k[49], k[57],
               k[2],  k[10], k[18], k[26], k[34], k[42], k[50], k[58],
               k[3],  k[11], k[19], k[27], k[35], k[43], k[51], k[59],
               k[36], k[44], k[52], k[60]};

  // PC-2: C/D bit n lives at cd[56-n]
  assign cd = {c_q, d_q};
  assign bus.subkey = {cd[42], cd[39], cd[45], cd[32], cd[55], cd[51], cd[53], cd[28],
                       cd[41], cd[50], cd[35], cd[46], cd[33], cd[37], cd[44], cd[52],
                       cd[30], cd[48], cd[40], cd[49], cd[29], cd[36], cd[43], cd[54],
                       cd[15], cd[4],  cd[25], cd[19], cd[9],  cd[1],  cd[26], cd[16],
                       cd[5],  cd[11], cd[23], cd[8],  cd[12], cd[7],  cd[17], cd[0],
                       cd[22], cd[3],  cd[10], cd[14], cd[6],  cd[20], cd[27], cd[24]};

  assign bus.idle         = (state_q == StIdle);
  assign bus.subkey_valid = (state_q == StRound);
  assign bus.round        = round_q;
  assign bus.last         = (state_q == StRound) && (round_q == 4'd15);

  assign fire = (state_q == StRound) && bus.subkey_ready;
  // Leaving deliveries 1, 8 and 15 shifts by one; the pattern is the same in both directions
  assign single_shift = (round_q == 4'd0) || (round_q == 4'd7) || (round_q == 4'd14);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    mode_d  = mode_q;
    case (state_q)
      StIdle: begin
        if (bus.key_load) begin
          mode_d  = bus.decrypt;
          // C16/D16 equal C0/D0, so decryption starts unrotated
          c_d     = bus.decrypt ? c0 : rotl(c0, 1'b0);
          d_d     = bus.decrypt ? d0 : rotl(d0, 1'b0);
          round_d = 4'd0;
          state_d = StRound;
        end
      end
      StRound: begin
        if (fire) begin
          if (round_q == 4'd15) begin
            state_d = StIdle;
            round_d = 4'd0;
          end else begin
            round_d = round_q + 4'd1;
            c_d     = mode_q ? rotr(c_q, !single_shift) : rotl(c_q, !single_shift);
            d_d     = mode_q ? rotr(d_q, !single_shift) : rotl(d_q, !single_shift);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      mode_q  <= mode_d;
    end
  end
endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: known-answer vectors, randomized keys and backpressure
// against a table-driven FIPS 46-3 key schedule model.
module tb_des_key_schedule;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  des_key_schedule_if bus();

  des_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                              10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                              63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                              14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2 [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                              23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                              41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] StdKey = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1     = 48'h1B02EFFC7072;
  localparam logic [47:0] K16    = 48'hCB3D8B0E17F5;

  typedef struct {
    logic [63:0] key;
    logic        dec;
    logic [47:0] first;
    logic [47:0] final_key;
  } vec_t;

  vec_t        vecs [3];
  logic [47:0] exp_ks [16];
  logic [47:0] got_ks [16];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Straight from the standard: PC-1, cumulative left shifts, PC-2; reversed for decryption
  task automatic compute_model(input logic [63:0] key, input logic dec);
    bit          c [28];
    bit          d [28];
    bit          tc, td;
    int          p;
    logic [47:0] enc [16];
    logic [47:0] ks;
    for (int i = 0; i < 28; i++) begin
      c[i] = key[64 - PC1[i]];
      d[i] = key[64 - PC1[i + 28]];
    end
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS[r]; s++) begin
        tc = c[0];
        td = d[0];
        for (int i = 0; i < 27; i++) begin
          c[i] = c[i + 1];
          d[i] = d[i + 1];
        end
        c[27] = tc;
        d[27] = td;
      end
      ks = '0;
      for (int j = 0; j < 48; j++) begin
        p = PC2[j];
        ks[47 - j] = (p <= 28) ? c[p - 1] : d[p - 29];
      end
      enc[r] = ks;
    end
    for (int i = 0; i < 16; i++) exp_ks[i] = dec ? enc[15 - i] : enc[i];
  endtask

  // One full schedule. load_at / rst_at inject key_load or rst at that round (-1 = never);
  // load_on_last raises key_load together with the final handshake.
  task automatic run_sched(input logic [63:0] key, input logic dec, input int ready_pct,
                           input int load_at, input int rst_at, input bit load_on_last);
    int          n = 0;
    int          cycles = 0;
    int          valid_cycles = 0;
    bit          prev_stall = 1'b0;
    logic [47:0] prev_sub = '0;
    logic [3:0]  prev_round = '0;
    bit          rdy;
    compute_model(key, dec);
    for (int i = 0; i < 16; i++) got_ks[i] = '0;
    @(negedge clk);
    check("idle_before_load", bus.idle, 1'b1);
    bus.key_in       = key;
    bus.decrypt      = dec;
    bus.key_load     = 1'b1;
    bus.subkey_ready = 1'b0;
    @(negedge clk);
    bus.key_load = 1'b0;
    bus.key_in   = {$urandom, $urandom};
    bus.decrypt  = ~dec;
    check("first_latency_valid", bus.subkey_valid, 1'b1);
    while (n < 16 && cycles < 1000) begin
      if (bus.subkey_valid !== 1'b1) begin
        check("valid_held", bus.subkey_valid, 1'b1);
        break;
      end
      valid_cycles++;
      if (prev_stall) begin
        check("stall_subkey_stable", bus.subkey, prev_sub);
        check("stall_round_stable", bus.round, prev_round);
      end
      if (rst_at >= 0 && int'(bus.round) == rst_at) begin
        rst              = 1'b1;
        bus.subkey_ready = 1'b0;
        @(negedge clk);
        check("rst_idle", bus.idle, 1'b1);
        check("rst_valid", bus.subkey_valid, 1'b0);
        check("rst_subkey", bus.subkey, 48'h0);
        check("rst_round", bus.round, 4'd0);
        check("rst_last", bus.last, 1'b0);
        rst = 1'b0;
        return;
      end
      rdy = ($urandom_range(0, 99) < ready_pct);
      bus.subkey_ready = rdy;
      if (load_at >= 0 && int'(bus.round) == load_at) begin
        bus.key_load = 1'b1;
        bus.key_in   = 64'h0;
      end
      if (load_on_last && rdy && bus.round == 4'd15) bus.key_load = 1'b1;
      if (rdy) begin
        got_ks[n] = bus.subkey;
        check($sformatf("subkey[%0d]", n), bus.subkey, exp_ks[n]);
        check($sformatf("round[%0d]", n), bus.round, n[3:0]);
        check($sformatf("last[%0d]", n), bus.last, n == 15);
        n++;
      end
      prev_stall = !rdy;
      prev_sub   = bus.subkey;
      prev_round = bus.round;
      @(negedge clk);
      cycles++;
      bus.key_load = 1'b0;
    end
    bus.subkey_ready = 1'b0;
    if (n < 16) begin
      checks++;
      errors++;
      $display("FAIL schedule_incomplete got %0d subkeys expected 16", n);
    end
    check("valid_after_last", bus.subkey_valid, 1'b0);
    check("idle_after_last", bus.idle, 1'b1);
    if (ready_pct >= 100) check("valid_cycle_count", valid_cycles, 16);
  endtask

  initial begin
    vecs[0] = '{StdKey, 1'b0, K1, K16};
    vecs[1] = '{StdKey, 1'b1, K16, K1};
    vecs[2] = '{64'h123457799BBCDFF0, 1'b0, K1, K16};

    bus.key_in       = '0;
    bus.decrypt      = 1'b0;
    bus.key_load     = 1'b0;
    bus.subkey_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_idle", bus.idle, 1'b1);
    check("reset_valid", bus.subkey_valid, 1'b0);
    check("reset_last", bus.last, 1'b0);
    check("reset_round", bus.round, 4'd0);
    check("reset_subkey", bus.subkey, 48'h0);

    foreach (vecs[i]) begin
      run_sched(vecs[i].key, vecs[i].dec, 100, -1, -1, 1'b0);
      check($sformatf("vec%0d_first", i), got_ks[0], vecs[i].first);
      check($sformatf("vec%0d_final", i), got_ks[15], vecs[i].final_key);
    end

    // Backpressure on the reference key
    run_sched(StdKey, 1'b0, 40, -1, -1, 1'b0);
    check("bp_first", got_ks[0], K1);
    check("bp_final", got_ks[15], K16);

    // key_load of an all-zero key at round 5 must not disturb the schedule
    run_sched(StdKey, 1'b0, 100, 5, -1, 1'b0);
    check("midload_final", got_ks[15], K16);

    // key_load coinciding with the final handshake is dropped
    run_sched(StdKey, 1'b1, 100, -1, -1, 1'b1);

    // Reset at round 7, then a clean restart
    run_sched(StdKey, 1'b0, 100, -1, 7, 1'b0);
    run_sched(StdKey, 1'b0, 100, -1, -1, 1'b0);
    check("restart_first", got_ks[0], K1);

    for (int t = 0; t < 4; t++) begin
      run_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)), 40, -1, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
